seq_alu: RTL and testbench
==========================

# seq_alu

Sequential 16-bit ALU with multi-cycle multiply and iterative shift. It sits directly upstream of the processor status register. It computes a 16-bit result and a 5-bit flag vector, then issues a one-cycle flag-load strobe. Its `flags` and `flags_ld` outputs connect straight to the status register's `flags_in` and `ld` inputs.

## Interface
- `WIDTH`, 16: datapath width. Only 16 is supported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only while idle.
- `op`  in  4  operation code, captured with `start`.
- `a`  in  16  operand A, captured with `start`.
- `b`  in  16  operand B, captured with `start`.
- `result`  out  16  registered result. Holds its value between operations.
- `flags`  out  5  registered flags {C, Z, S, V, P}, bit 4 down to bit 0.
- `flags_ld`  out  1  one-cycle strobe, coincident with `done` on flag-producing ops.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT a.
  - 6 SHL: a shifted left by b[3:0].
  - 7 SHR: a logically shifted right by b[3:0].
  - 8 MUL: low 16 bits of the unsigned a*b.
  - 9 CMP: a-b; updates flags only, `result` is unchanged.
  - 10-15: reserved.
- FSM states:
  - IDLE: start=1 latches op, a, b → EXEC (ops 0-5, 9, 10-15), SHIFT (ops 6-7), or MUL (op 8).
  - EXEC: single cycle → IDLE, with the completion registered.
  - SHIFT: one bit per cycle. A 4-bit counter is loaded with b[3:0]; when the count is 0 → IDLE, with the completion registered.
  - MUL: shift-add, one multiplier bit per cycle, 16 iterations, 32-bit internal product → IDLE, with the completion registered.
- Flag rules (computed on the 16-bit output value):
  - Z = (value == 0).
  - S = value[15].
  - P = 1 when the value has an even number of 1 bits.
  - C:
    - ADD: carry-out.
    - SUB/CMP: borrow, i.e. 1 when a < b unsigned.
    - SHL/SHR: last bit shifted out; 0 when the count is 0.
    - MUL: 1 when product[31:16] != 0.
    - Logic ops: 0.
  - V:
    - ADD/SUB/CMP: signed two's-complement overflow.
    - MUL: equal to C.
    - All other ops: 0.
- Reserved ops: `done` pulses, `flags_ld` stays 0, and `result`/`flags` are unchanged.
- `start` while `busy` is ignored. The operation in progress continues unaffected.
- Operand or `op` changes after capture have no effect.
- `flags` updates only at completion of a flag-producing op (0-9).

## Timing
- Reset (rst=0, asynchronous, any state, including mid-MUL/SHIFT):
  - FSM → IDLE.
  - result=0x0000, flags=5'b00000, flags_ld=0, busy=0, done=0.
  - The partial operation is discarded; no `done` or `flags_ld` is issued for it.
- `start` sampled at edge 0 → `busy`=1 from edge 0.
- Completion edge:
  - EXEC ops: edge 1.
  - SHIFT with n = b[3:0]: edge n+1, so n=0 completes at edge 1.
  - MUL: edge 17.
- At the completion edge, in the same cycle:
  - `result`, `flags`, `done`=1 and `flags_ld`=1 become valid.
  - `busy`=0.
- `done` and `flags_ld` last exactly one cycle.
- A `start` present during the `done` cycle is accepted (back-to-back issue); that edge becomes edge 0 of the next op.
- The status register loads `flags` on the edge following the completion edge.

## Test plan
- ADD a=0x7FFF, b=0x0001 → edge 1: result=0x8000, flags=5'b00110, done=flags_ld=1 for one cycle.
- SUB a=b=0x0005 → result=0x0000, flags=5'b01001. Follow with CMP a=0x0003, b=0x0005 started in the `done` cycle → result stays 0x0000, flags=5'b10100.
- SHL a=0x8001, b=0x0001 → done at edge 2, result=0x0002, flags=5'b10000. SHR with b=0 → done at edge 1, result=a, C=0.
- MUL a=0x0100, b=0x0100 → busy for 17 cycles, done at edge 17, result=0x0000, flags=5'b11011. A `start` pulsed at edge 5 is ignored: exactly one `done`, at edge 17.
- Reset: MUL started, rst=0 at cycle 8 → all outputs 0 immediately. After release, no `done` or `flags_ld` appears; a new ADD 1+1 → result=0x0002, flags=5'b00000 at edge 1.
- Reserved op 0xF → done at edge 1, flags_ld=0, result and flags unchanged.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential 16-bit ALU feeding the processor status register: single-cycle logic/arith ops,
// an iterative shifter (one bit per cycle) and a 16-step shift-add multiplier.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             flags_ld,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_MUL
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam logic [4:0] MUL_ITERS = 5'(WIDTH);

    // Flag vector layout is {C, Z, S, V, P}; P is set for even parity.
    function automatic logic [4:0] make_flags(input logic c, input logic v,
                                              input logic [WIDTH-1:0] value);
        return {c, (value == '0), value[WIDTH-1], v, ~^value};
    endfunction

    state_t             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH-1:0]   r_sh;
    logic [3:0]         r_sh_cnt;
    logic               r_sh_c;

    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [4:0]         r_mul_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_add_v;
    logic               w_sub_v;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_add_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
    assign w_sub_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);

    logic [WIDTH-1:0]   w_ex_val;
    logic               w_ex_c;
    logic               w_ex_v;
    logic               w_ex_wr;
    logic               w_ex_ld;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_ex_val = '0;
        w_ex_c   = 1'b0;
        w_ex_v   = 1'b0;
        w_ex_wr  = 1'b1;
        w_ex_ld  = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_ex_val = w_sum[WIDTH-1:0];
                w_ex_c   = w_sum[WIDTH];
                w_ex_v   = w_add_v;
            end
            OP_SUB: begin
                w_ex_val = w_diff[WIDTH-1:0];
                w_ex_c   = w_diff[WIDTH];
                w_ex_v   = w_sub_v;
            end
            OP_CMP: begin
                w_ex_val = w_diff[WIDTH-1:0];
                w_ex_c   = w_diff[WIDTH];
                w_ex_v   = w_sub_v;
                w_ex_wr  = 1'b0;
            end
            OP_AND: w_ex_val = r_a & r_b;
            OP_OR:  w_ex_val = r_a | r_b;
            OP_XOR: w_ex_val = r_a ^ r_b;
            OP_NOT: w_ex_val = ~r_a;
            default: begin
                w_ex_wr = 1'b0;
                w_ex_ld = 1'b0;
            end
        endcase
    end

    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_out;

    assign w_sh_out  = (r_op == OP_SHL) ? r_sh[WIDTH-1] : r_sh[0];
    assign w_sh_next = (r_op == OP_SHL) ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_hi;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_hi    = |r_prod[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sh      <= '0;
            r_sh_cnt  <= '0;
            r_sh_c    <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_mul_cnt <= '0;
            result    <= '0;
            flags     <= '0;
            flags_ld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            flags_ld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                        busy <= 1'b1;
                        if (op == OP_SHL || op == OP_SHR) begin
                            r_sh     <= a;
                            r_sh_cnt <= b[3:0];
                            r_sh_c   <= 1'b0;
                            r_state  <= S_SHIFT;
                        end else if (op == OP_MUL) begin
                            r_prod    <= '0;
                            r_mcand   <= {{WIDTH{1'b0}}, a};
                            r_mplier  <= b;
                            r_mul_cnt <= '0;
                            r_state   <= S_MUL;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    flags_ld <= w_ex_ld;
                    if (w_ex_wr) result <= w_ex_val;
                    if (w_ex_ld) flags  <= make_flags(w_ex_c, w_ex_v, w_ex_val);
                end

                // A zero count completes immediately with C cleared, since nothing was shifted out.
                S_SHIFT: begin
                    if (r_sh_cnt == 4'd0) begin
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        flags_ld <= 1'b1;
                        result   <= r_sh;
                        flags    <= make_flags(r_sh_c, 1'b0, r_sh);
                    end else begin
                        r_sh     <= w_sh_next;
                        r_sh_c   <= w_sh_out;
                        r_sh_cnt <= r_sh_cnt - 4'd1;
                    end
                end

                S_MUL: begin
                    if (r_mul_cnt == MUL_ITERS) begin
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        flags_ld <= 1'b1;
                        result   <= r_prod[WIDTH-1:0];
                        flags    <= make_flags(w_mul_hi, w_mul_hi, r_prod[WIDTH-1:0]);
                    end else begin
                        r_prod    <= w_prod_next;
                        r_mcand   <= r_mcand << 1;
                        r_mplier  <= r_mplier >> 1;
                        r_mul_cnt <= r_mul_cnt + 5'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases from the datasheet plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        flags_ld;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural state the status register should see.
    logic [15:0] m_result = '0;
    logic [4:0]  m_flags  = '0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .flags(flags), .flags_ld(flags_ld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                         output int lat, output logic ld);
        logic [31:0] wide;
        logic [15:0] v;
        logic        c;
        logic        ov;
        int          n;
        int          s;
        n = int'(mb[3:0]);
        wide = '0; v = '0; c = 1'b0; ov = 1'b0; s = 0;
        lat = 1; ld = 1'b1;
        case (mop)
            4'd0: begin
                wide = 32'(ma) + 32'(mb);
                v  = wide[15:0];
                c  = wide[16];
                s  = int'($signed(ma)) + int'($signed(mb));
                ov = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd9: begin
                v  = ma - mb;
                c  = (ma < mb);
                s  = int'($signed(ma)) - int'($signed(mb));
                ov = (s > 32767) || (s < -32768);
            end
            4'd2: v = ma & mb;
            4'd3: v = ma | mb;
            4'd4: v = ma ^ mb;
            4'd5: v = ~ma;
            4'd6: begin
                wide = 32'(ma) << n;
                v   = wide[15:0];
                c   = (n == 0) ? 1'b0 : wide[16];
                lat = n + 1;
            end
            4'd7: begin
                v   = ma >> n;
                c   = (n == 0) ? 1'b0 : ma[n-1];
                lat = n + 1;
            end
            4'd8: begin
                wide = 32'(ma) * 32'(mb);
                v   = wide[15:0];
                c   = (wide[31:16] != 16'h0);
                ov  = c;
                lat = 17;
            end
            default: ld = 1'b0;
        endcase
        if (ld) begin
            m_flags = {c, (v == 16'h0), v[15], ov, (($countones(v) % 2) == 0)};
            if (mop != 4'd9) m_result = v;
        end
    endtask

    // Issues one op (start asserted in the cycle before the next edge) and waits for done.
    task automatic do_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic [15:0] res, output logic [4:0] fl,
                         output logic ld, output logic busy0);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        busy0 = busy;
        start = 1'b0;
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        lat = -1; res = 'x; fl = 'x; ld = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; res = result; fl = flags; ld = flags_ld;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
        n_checks++; if (flags !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", flags); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (flags_ld !== 1'b0) begin n_fail++; $display("FAIL reset_flags_ld: got %b want 0", flags_ld); end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: busy/done got %b want 00", {busy, done}); end
    endtask

    task automatic test_add();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld;
        model(4'd0, 16'h7FFF, 16'h0001, mlat, mld);
        do_op(4'd0, 16'h7FFF, 16'h0001, lat, res, fl, ld, b0);
        n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL add_busy_edge0: got %b want 1", b0); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_checks++; if (res !== 16'h8000) begin n_fail++; $display("FAIL add_result: got %h want 8000", res); end
        n_checks++; if (fl !== 5'b00110) begin n_fail++; $display("FAIL add_flags: got %b want 00110", fl); end
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL add_flags_ld: got %b want 1", ld); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        n_checks++; if ({done, flags_ld} !== 2'b00) begin n_fail++; $display("FAIL add_pulse_width: done/ld got %b want 00", {done, flags_ld}); end
    endtask

    task automatic test_sub_cmp();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld;
        model(4'd1, 16'h0005, 16'h0005, mlat, mld);
        do_op(4'd1, 16'h0005, 16'h0005, lat, res, fl, ld, b0);
        n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL sub_result: got %h want 0000", res); end
        n_checks++; if (fl !== 5'b01001) begin n_fail++; $display("FAIL sub_flags: got %b want 01001", fl); end
        // CMP issued during the SUB done cycle
        model(4'd9, 16'h0003, 16'h0005, mlat, mld);
        do_op(4'd9, 16'h0003, 16'h0005, lat, res, fl, ld, b0);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL cmp_b2b_latency: got %0d want 1", lat); end
        n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL cmp_result_held: got %h want 0000", res); end
        n_checks++; if (fl !== 5'b10100) begin n_fail++; $display("FAIL cmp_flags: got %b want 10100", fl); end
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL cmp_flags_ld: got %b want 1", ld); end
    endtask

    task automatic test_shift();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld;
        model(4'd6, 16'h8001, 16'h0001, mlat, mld);
        do_op(4'd6, 16'h8001, 16'h0001, lat, res, fl, ld, b0);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL shl1_latency: got %0d want 2", lat); end
        n_checks++; if (res !== 16'h0002) begin n_fail++; $display("FAIL shl1_result: got %h want 0002", res); end
        n_checks++; if (fl !== 5'b10000) begin n_fail++; $display("FAIL shl1_flags: got %b want 10000", fl); end
        // only b[3:0] is the count, so 0xFFF0 means a zero shift
        model(4'd7, 16'hA5C3, 16'hFFF0, mlat, mld);
        do_op(4'd7, 16'hA5C3, 16'hFFF0, lat, res, fl, ld, b0);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL shr0_latency: got %0d want 1", lat); end
        n_checks++; if (res !== 16'hA5C3) begin n_fail++; $display("FAIL shr0_result: got %h want a5c3", res); end
        n_checks++; if (fl[4] !== 1'b0) begin n_fail++; $display("FAIL shr0_carry: got %b want 0", fl[4]); end
        model(4'd7, 16'h8001, 16'h000F, mlat, mld);
        do_op(4'd7, 16'h8001, 16'h000F, lat, res, fl, ld, b0);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL shr15_latency: got %0d want 16", lat); end
        n_checks++; if ({res, fl} !== {16'h0001, 5'b00000}) begin n_fail++; $display("FAIL shr15_result_flags: got %h/%b want 0001/00000", res, fl); end
    endtask

    task automatic test_mul_ignore_start();
        int mlat; logic mld; int n_done; int first_done; int busy_drop;
        logic [15:0] res; logic [4:0] fl; logic ld; logic b0;
        n_done = 0; first_done = -1; busy_drop = 0; res = 'x; fl = 'x; ld = 1'b0;
        model(4'd8, 16'h0100, 16'h0100, mlat, mld);
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = 16'h0100; b = 16'h0100;
        @(posedge clk); #1;
        b0 = busy;
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 5) begin start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (first_done < 0) begin first_done = k; res = result; fl = flags; ld = flags_ld; end
            end
            if (k < 17 && busy !== 1'b1) busy_drop++;
        end
        start = 1'b0;
        n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL mul_busy_edge0: got %b want 1", b0); end
        n_checks++; if (busy_drop !== 0) begin n_fail++; $display("FAIL mul_busy_held: %0d cycles low, want 0", busy_drop); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL mul_done_count: got %0d want 1", n_done); end
        n_checks++; if (first_done !== 17) begin n_fail++; $display("FAIL mul_latency: got %0d want 17", first_done); end
        n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL mul_result: got %h want 0000", res); end
        n_checks++; if (fl !== 5'b11011) begin n_fail++; $display("FAIL mul_flags: got %b want 11011", fl); end
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL mul_flags_ld: got %b want 1", ld); end
    endtask

    task automatic test_reset_mid();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld; int stray;
        model(4'd0, 16'h1234, 16'h1111, mlat, mld);
        do_op(4'd0, 16'h1234, 16'h1111, lat, res, fl, ld, b0);
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({result, flags, busy, done, flags_ld} !== 24'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b%b%b want all zero", result, flags, busy, done, flags_ld);
        end
        m_result = '0; m_flags = '0;
        @(negedge clk); rst = 1'b1;
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || flags_ld || busy) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midreset_stray: got %0d active cycles want 0", stray); end
        model(4'd0, 16'h0001, 16'h0001, mlat, mld);
        do_op(4'd0, 16'h0001, 16'h0001, lat, res, fl, ld, b0);
        n_checks++; if ({res, fl} !== {16'h0002, 5'b00000}) begin n_fail++; $display("FAIL midreset_add: got %h/%b want 0002/00000", res, fl); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL midreset_add_latency: got %0d want 1", lat); end
    endtask

    task automatic test_reserved();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld;
        model(4'd4, 16'hF0F0, 16'h0FF0, mlat, mld);
        do_op(4'd4, 16'hF0F0, 16'h0FF0, lat, res, fl, ld, b0);
        n_checks++; if ({res, fl} !== {16'hFF00, 5'b00101}) begin n_fail++; $display("FAIL xor_setup: got %h/%b want ff00/00101", res, fl); end
        for (int o = 10; o <= 15; o++) begin
            do_op(4'(o), 16'($urandom), 16'($urandom), lat, res, fl, ld, b0);
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL reserved%0d_latency: got %0d want 1", o, lat); end
            n_checks++; if (ld !== 1'b0) begin n_fail++; $display("FAIL reserved%0d_flags_ld: got %b want 0", o, ld); end
            n_checks++; if ({res, fl} !== {m_result, m_flags}) begin
                n_fail++; $display("FAIL reserved%0d_unchanged: got %h/%b want %h/%b", o, res, fl, m_result, m_flags);
            end
        end
    endtask

    task automatic test_random();
        int lat; int mlat; logic [15:0] res; logic [4:0] fl; logic ld; logic b0; logic mld;
        logic [3:0] o; logic [15:0] x; logic [15:0] y; int gap;
        logic [15:0] edge_vals [4];
        edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h8000; edge_vals[3] = 16'h7FFF;
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : 16'($urandom);
            gap = $urandom_range(0, 2);
            model(o, x, y, mlat, mld);
            do_op(o, x, y, lat, res, fl, ld, b0);
            n_checks++; if (lat !== mlat) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, o, lat, mlat); end
            n_checks++; if (ld !== mld) begin n_fail++; $display("FAIL rnd%0d_flags_ld op=%0d: got %b want %b", i, o, ld, mld); end
            n_checks++; if (res !== m_result) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, x, y, res, m_result); end
            n_checks++; if (fl !== m_flags) begin n_fail++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h: got %b want %b", i, o, x, y, fl, m_flags); end
            if (gap > 0) begin
                @(posedge clk); #1;
                n_checks++; if ({done, flags_ld, busy} !== 3'b000) begin n_fail++; $display("FAIL rnd%0d_idle: done/ld/busy got %b want 000", i, {done, flags_ld, busy}); end
                repeat (gap - 1) @(posedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_shift();
        test_mul_ignore_start();
        test_reset_mid();
        test_reserved();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
